spi_cmd_engine: RTL and testbench

Oversampled SPI slave front-end for the 32-line I/O expander. Runs entirely in the system clock domain, synchronises the external SPI pins, deframes each transaction into a command byte and data byte(s), and issues single-cycle register read/write strobes to the expander's register bus. It sits directly upstream of the port/address-decode logic and replaces the SPI-clocked shifter with a fully synchronous design.

---
 rtl/spi_io_pkg.sv | 29 ++
 rtl/spi_cmd_engine_if.sv | 23 ++
 rtl/spi_pin_sync.sv | 43 ++++
 rtl/spi_cmd_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_cmd_engine.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_io_pkg.sv
// Shared definitions for the SPI command engine.
//   - FSM state encoding used by spi_cmd_engine
//   - read/write flag values carried in bit 7 of the command byte
//   - default register address width and frame byte width
//   - frame shift helper
package spi_io_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int FRAME_W    = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // ST_HOLD parks a finished single-byte frame until chip select releases
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RLOAD = 3'd3,
        ST_RDATA = 3'd4,
        ST_HOLD  = 3'd5
    } spi_state_e;

    // Shift a frame one place towards the MSB, filling with zero
    function automatic logic [FRAME_W-1:0] shl_frame(input logic [FRAME_W-1:0] v);
        return {v[FRAME_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/spi_cmd_engine_if.sv
// Register-bus interface between the SPI command engine and the expander.
//   regAddr  : register address of the current access
//   regWdata : write data
//   regWr    : one-cycle write strobe
//   regRd    : one-cycle read strobe
//   regRdata : read data, valid the cycle after regRd
// master = engine side, slave = register file side.
interface spi_cmd_engine_if #(
    parameter int ADDR_W = spi_io_pkg::ADDR_W_DEF
) ();

    logic [ADDR_W-1:0]              regAddr;
    logic [spi_io_pkg::FRAME_W-1:0] regWdata;
    logic                           regWr;
    logic                           regRd;
    logic [spi_io_pkg::FRAME_W-1:0] regRdata;

    modport master (output regAddr, output regWdata, output regWr, output regRd,
                    input  regRdata);
    modport slave  (input  regAddr, input  regWdata, input  regWr, input  regRd,
                    output regRdata);

endinterface

// File: rtl/spi_pin_sync.sv
// Synchroniser and edge detector for one asynchronous SPI pin.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous pin
//   rise     : one-cycle pulse on a synchronised 0->1 transition
//   fall     : one-cycle pulse on a synchronised 1->0 transition
// The chain resets to 0 so a pin already low at reset release produces no
// edge; a chip select held low through reset therefore cannot start a frame.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q, chain_d;
    logic                   prev_q, prev_d;
    logic                   sync_s;

    // Next values of the synchroniser chain and the edge-history flop
    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], din};
        prev_d  = chain_q[SYNC_STAGES-1];
    end

    // Synchroniser chain and delayed copy of its output
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {SYNC_STAGES{1'b0}};
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_s = chain_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~prev_q;
    assign fall   = ~sync_s & prev_q;

endmodule

// File: rtl/spi_cmd_engine.sv
// Oversampled SPI (mode 0) slave front-end issuing register bus accesses.
//   clk, rst       : system clock, synchronous active-high reset
//   sclk, en, mosi : asynchronous SPI pins (en active-low chip select)
//   miso, misoOe   : serial read data (MSB first) and its output enable
//   busy           : frame in progress
//   reg_bus        : register bus (address, write data, strobes, read data)
// Frame: command byte {rw, addr} followed by data bytes.
// Optional feature macro SPI_BURST_EN: when defined, every data byte advances
// the address and the frame may continue indefinitely; otherwise only the
// first data byte is acted on and the rest of the frame is ignored.
module spi_cmd_engine
    import spi_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             en,
    input  logic             mosi,
    output logic             miso,
    output logic             misoOe,
    output logic             busy,
    spi_cmd_engine_if.master reg_bus
);

    localparam int CNT_W = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
`ifdef SPI_BURST_EN
    localparam logic BURST = 1'b1;
`else
    localparam logic BURST = 1'b0;
`endif

    spi_state_e             state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-2:0]     rx_shift_q, rx_shift_d;
    logic [FRAME_W-1:0]     tx_shift_q, tx_shift_d;
    logic                   armed_q, armed_d;
    logic [ADDR_W-1:0]      reg_addr_q, reg_addr_d;
    logic [FRAME_W-1:0]     reg_wdata_q, reg_wdata_d;
    logic                   reg_wr_q, reg_wr_d;
    logic                   reg_rd_q, reg_rd_d;
    logic                   busy_q, busy_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

    logic                   mosi_s;
    logic                   sclk_rise_s, sclk_fall_s;
    logic                   en_rise_s, en_fall_s;
    logic                   byte_end_s;
    logic                   abort_s;
    logic [FRAME_W-1:0]     rx_byte_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(sclk), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_en_sync (
        .clk(clk), .rst(rst), .din(en), .rise(en_rise_s), .fall(en_fall_s)
    );

    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign byte_end_s = (bit_cnt_q == CNT_LAST);
    assign rx_byte_s  = {rx_shift_q, mosi_s};
    assign abort_s    = en_rise_s && (state_q != ST_IDLE);

    // Frame deframing FSM: next state, shift registers and bus strobes
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        armed_d     = armed_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};

        case (state_q)
            ST_IDLE: begin
                if (en_fall_s) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (sclk_rise_s && byte_end_s) begin
                    bit_cnt_d  = {CNT_W{1'b0}};
                    reg_addr_d = rx_byte_s[ADDR_W-1:0];
                    if (rx_byte_s[FRAME_W-1] == RW_READ) begin
                        state_d  = ST_RLOAD;
                        reg_rd_d = 1'b1;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end else if (sclk_rise_s) begin
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    rx_shift_d = rx_byte_s[FRAME_W-2:0];
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_WDATA: begin
                // Address advances after the strobe cycle so the strobe sees the old address
                if (BURST && reg_wr_q) begin
                    reg_addr_d = reg_addr_q + ADDR_W'(1);
                end else begin
                    reg_addr_d = reg_addr_q;
                end
                if (sclk_rise_s && byte_end_s) begin
                    bit_cnt_d   = {CNT_W{1'b0}};
                    reg_wdata_d = rx_byte_s;
                    reg_wr_d    = 1'b1;
                    state_d     = BURST ? ST_WDATA : ST_HOLD;
                end else if (sclk_rise_s) begin
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    rx_shift_d = rx_byte_s[FRAME_W-2:0];
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_RLOAD: begin
                // Stay through the strobe cycle; read data is valid the cycle after
                if (reg_rd_q) begin
                    state_d = ST_RLOAD;
                end else begin
                    tx_shift_d = reg_bus.regRdata;
                    bit_cnt_d  = {CNT_W{1'b0}};
                    armed_d    = 1'b0;
                    state_d    = ST_RDATA;
                end
            end
            ST_RDATA: begin
                // Only a fall that follows a rise of this byte shifts; this skips
                // the trailing fall of the previous byte seen after RLOAD.
                if (sclk_rise_s) begin
                    armed_d = 1'b1;
                end else if (sclk_fall_s && armed_q && byte_end_s) begin
                    armed_d    = 1'b0;
                    bit_cnt_d  = {CNT_W{1'b0}};
                    tx_shift_d = shl_frame(tx_shift_q);
                    if (BURST) begin
                        reg_addr_d = reg_addr_q + ADDR_W'(1);
                        reg_rd_d   = 1'b1;
                        state_d    = ST_RLOAD;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else if (sclk_fall_s && armed_q) begin
                    armed_d    = 1'b0;
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    tx_shift_d = shl_frame(tx_shift_q);
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_HOLD: begin
                state_d = ST_HOLD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Chip-select release wins over the FSM, but a write strobe computed
        // on the same cycle is kept.
        state_d   = abort_s ? ST_IDLE : state_d;
        bit_cnt_d = abort_s ? {CNT_W{1'b0}} : bit_cnt_d;
        reg_rd_d  = abort_s ? 1'b0 : reg_rd_d;

        busy_d    = (state_d != ST_IDLE);
        miso_oe_d = busy_d;
        miso_d    = (state_d == ST_RDATA) ? tx_shift_d[FRAME_W-1] : 1'b0;
    end

    // Engine state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= {CNT_W{1'b0}};
            rx_shift_q  <= {(FRAME_W-1){1'b0}};
            tx_shift_q  <= {FRAME_W{1'b0}};
            armed_q     <= 1'b0;
            reg_addr_q  <= {ADDR_W{1'b0}};
            reg_wdata_q <= {FRAME_W{1'b0}};
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            armed_q     <= armed_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            busy_q      <= busy_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign miso             = miso_q;
    assign misoOe           = miso_oe_q;
    assign busy             = busy_q;
    assign reg_bus.regAddr  = reg_addr_q;
    assign reg_bus.regWdata = reg_wdata_q;
    assign reg_bus.regWr    = reg_wr_q;
    assign reg_bus.regRd    = reg_rd_q;

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Directed testbench for spi_cmd_engine: drives SPI mode-0 frames, models the
// register file read data as {addr[3:0], ~addr[3:0]}, logs every bus strobe
// and checks against hand-computed values. Expected values for the burst
// scenarios follow the SPI_BURST_EN build option.
module tb_spi_cmd_engine;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst;
    logic sclk;
    logic en;
    logic mosi;
    logic miso;
    logic misoOe;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic [6:0] wr_addr [0:31];
    logic [7:0] wr_data [0:31];
    logic [6:0] rd_addr [0:31];

    logic [7:0] tx_buf [0:3];
    logic [7:0] rx_buf [0:3];

    spi_cmd_engine_if #(.ADDR_W(7)) reg_bus ();

    assign reg_bus.regRdata = {reg_bus.regAddr[3:0], ~reg_bus.regAddr[3:0]};

    spi_cmd_engine #(.SYNC_STAGES(2), .ADDR_W(7)) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .en      (en),
        .mosi    (mosi),
        .miso    (miso),
        .misoOe  (misoOe),
        .busy    (busy),
        .reg_bus (reg_bus)
    );

    always #5 clk = ~clk;

    // Log every register bus strobe away from the active edge
    always @(negedge clk) begin
        if (reg_bus.regWr) begin
            if (wr_cnt < 32) begin
                wr_addr[wr_cnt] <= reg_bus.regAddr;
                wr_data[wr_cnt] <= reg_bus.regWdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (reg_bus.regRd) begin
            if (rd_cnt < 32) begin
                rd_addr[rd_cnt] <= reg_bus.regAddr;
            end
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send the top nbits of tx MSB first; miso is captured at each rising sclk
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic release_on_last,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            tick(HALF);
            sclk  = 1'b1;
            rx[i] = miso;
            if (release_on_last && (i == 8 - nbits)) en = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input int nbytes, input logic release_on_last);
        logic [7:0] r;
        en = 1'b0;
        tick(6);
        for (int b = 0; b < nbytes; b++) begin
            spi_bits(tx_buf[b], 8, release_on_last && (b == nbytes - 1), r);
            rx_buf[b] = r;
        end
        if (!release_on_last) begin
            tick(HALF);
            en = 1'b1;
        end
        tick(10);
    endtask

    initial begin
        int wb;
        int rb;
        logic [7:0] r;

        rst  = 1'b1;
        en   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(4);

        check_eq("rst_miso",     miso,             0);
        check_eq("rst_misoOe",   misoOe,           0);
        check_eq("rst_busy",     busy,             0);
        check_eq("rst_regAddr",  reg_bus.regAddr,  0);
        check_eq("rst_regWdata", reg_bus.regWdata, 0);
        check_eq("rst_regWr",    reg_bus.regWr,    0);
        check_eq("rst_regRd",    reg_bus.regRd,    0);

        // Single write 0x05 <- 0xA5
        wb = wr_cnt; rb = rd_cnt;
        en = 1'b0;
        tick(6);
        check_eq("wr_busy_on",   busy,   1);
        check_eq("wr_misoOe_on", misoOe, 1);
        spi_bits(8'h05, 8, 1'b0, r);
        spi_bits(8'hA5, 8, 1'b0, r);
        tick(HALF);
        en = 1'b1;
        tick(10);
        check_eq("wr_count",  wr_cnt - wb, 1);
        check_eq("wr_addr",   wr_addr[wb], 7'h05);
        check_eq("wr_data",   wr_data[wb], 8'hA5);
        check_eq("wr_no_rd",  rd_cnt - rb, 0);
        check_eq("wr_busy_off", busy, 0);

        // Reset in the middle of a read data byte
        en = 1'b0;
        tick(6);
        spi_bits(8'h83, 8, 1'b0, r);
        spi_bits(8'h00, 3, 1'b0, r);
        check_eq("mid_misoOe_pre", misoOe, 1);
        rst = 1'b1;
        tick(2);
        check_eq("mid_miso",     miso,             0);
        check_eq("mid_misoOe",   misoOe,           0);
        check_eq("mid_busy",     busy,             0);
        check_eq("mid_regAddr",  reg_bus.regAddr,  0);
        check_eq("mid_regWdata", reg_bus.regWdata, 0);
        rst = 1'b0;
        wb = wr_cnt; rb = rd_cnt;
        spi_bits(8'hFF, 5, 1'b0, r);
        check_eq("mid_stay_idle", busy, 0);
        check_eq("mid_no_strobe", (wr_cnt - wb) + (rd_cnt - rb), 0);
        en = 1'b1;
        tick(10);

        // Single read at 0x03, register data 0x3C
        wb = wr_cnt; rb = rd_cnt;
        tx_buf[0] = 8'h83; tx_buf[1] = 8'h00;
        spi_frame(2, 1'b0);
        check_eq("rd_count",  rd_cnt - rb, 1);
        check_eq("rd_addr",   rd_addr[rb], 7'h03);
        check_eq("rd_miso",   rx_buf[1],   8'h3C);
        check_eq("rd_no_wr",  wr_cnt - wb, 0);
        check_eq("rd_oe_off", misoOe, 0);
        check_eq("rd_miso_off", miso, 0);

        // Write burst starting at 0x7F: address wraps to 0x00
        wb = wr_cnt;
        tx_buf[0] = 8'h7F; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
        spi_frame(3, 1'b0);
        check_eq("bw_addr0", wr_addr[wb], 7'h7F);
        check_eq("bw_data0", wr_data[wb], 8'h11);
`ifdef SPI_BURST_EN
        check_eq("bw_count", wr_cnt - wb,     2);
        check_eq("bw_addr1", wr_addr[wb + 1], 7'h00);
        check_eq("bw_data1", wr_data[wb + 1], 8'h22);
`else
        check_eq("bw_count", wr_cnt - wb, 1);
`endif

        // Read burst starting at 0x04
        rb = rd_cnt;
        tx_buf[0] = 8'h84; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        spi_frame(3, 1'b0);
        check_eq("br_addr0", rd_addr[rb], 7'h04);
        check_eq("br_miso0", rx_buf[1],   8'h4B);
`ifdef SPI_BURST_EN
        check_eq("br_count", rd_cnt - rb,     3);
        check_eq("br_addr1", rd_addr[rb + 1], 7'h05);
        check_eq("br_miso1", rx_buf[2],       8'h5A);
`else
        check_eq("br_count", rd_cnt - rb, 1);
        check_eq("br_miso1", rx_buf[2],   8'h00);
`endif

        // Abort after 5 data bits, then a normal frame
        wb = wr_cnt;
        en = 1'b0;
        tick(6);
        spi_bits(8'h10, 8, 1'b0, r);
        spi_bits(8'hA8, 5, 1'b0, r);
        tick(HALF);
        en = 1'b1;
        tick(10);
        check_eq("ab_no_wr", wr_cnt - wb, 0);
        check_eq("ab_busy",  busy,        0);
        wb = wr_cnt;
        tx_buf[0] = 8'h21; tx_buf[1] = 8'h5A;
        spi_frame(2, 1'b0);
        check_eq("ab_next_count", wr_cnt - wb, 1);
        check_eq("ab_next_addr",  wr_addr[wb], 7'h21);
        check_eq("ab_next_data",  wr_data[wb], 8'h5A);

        // Chip select released together with the 8th data rise
        wb = wr_cnt;
        tx_buf[0] = 8'h33; tx_buf[1] = 8'hC6;
        spi_frame(2, 1'b1);
        check_eq("sim_count", wr_cnt - wb, 1);
        check_eq("sim_addr",  wr_addr[wb], 7'h33);
        check_eq("sim_data",  wr_data[wb], 8'hC6);
        check_eq("sim_busy",  busy,        0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
